// File: rtl/wiener_n_channel_block.sv
// Block-adaptive Wiener denoiser: buffers a block of packed pixels, derives per-channel
// mean/variance and gain, then emits y = mean + g*(x-mean) through a valid/ready port.
module wiener_n_channel_block #(
  parameter int unsigned NUM_CHANNELS  = 3,
  parameter int unsigned CH_WIDTH      = 8,
  parameter int unsigned BLOCK_SAMPLES = 8,
  parameter int unsigned GAIN_FRAC     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_of_frame,
  input  logic                             end_of_frame,
  input  logic                             start_data,
  input  logic                             data_valid,
  output logic                             in_ready,
  input  logic [NUM_CHANNELS*CH_WIDTH-1:0] data_in,
  input  logic [2*CH_WIDTH-1:0]            noise_variance,
  input  logic                             bypass,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_CHANNELS*CH_WIDTH-1:0] data_out,
  output logic                             out_start_block,
  output logic                             frame_done,
  output logic [31:0]                      data_count
);

  localparam int unsigned DataW  = NUM_CHANNELS * CH_WIDTH;
  localparam int unsigned LogB   = $clog2(BLOCK_SAMPLES);
  localparam int unsigned IdxW   = LogB;
  localparam int unsigned KW     = LogB + 1;
  localparam int unsigned SumW   = CH_WIDTH + LogB;
  localparam int unsigned SqW    = 2 * CH_WIDTH + LogB;
  localparam int unsigned VarW   = 2 * CH_WIDTH;
  localparam int unsigned GainW  = GAIN_FRAC + 1;
  localparam int unsigned ChIdxW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned CntW   = (GAIN_FRAC > 0) ? $clog2(GAIN_FRAC + 1) : 1;
  localparam int unsigned ProdW  = CH_WIDTH + GAIN_FRAC + 3;

  typedef enum logic [2:0] {StIdle, StLoad, StStats, StDivide, StEmit} state_e;

  // Signed floor-shifted gain applied around the mean, clamped to the channel range.
  function automatic logic [CH_WIDTH-1:0] filter_px(input logic [CH_WIDTH-1:0] x,
                                                    input logic [CH_WIDTH-1:0] mean,
                                                    input logic [GainW-1:0]    g);
    logic signed [ProdW-1:0] diff;
    logic signed [ProdW-1:0] prod;
    logic signed [ProdW-1:0] ysum;
    diff = $signed(ProdW'(x)) - $signed(ProdW'(mean));
    prod = diff * $signed(ProdW'(g));
    ysum = (prod >>> GAIN_FRAC) + $signed(ProdW'(mean));
    if (ysum[ProdW-1]) return '0;
    else if (|ysum[ProdW-2:CH_WIDTH]) return '1;
    else return ysum[CH_WIDTH-1:0];
  endfunction

  function automatic logic [VarW-1:0] calc_var(input logic [SqW-1:0]      sq,
                                               input logic [CH_WIDTH-1:0] mean);
    logic [VarW-1:0] msq;
    msq = VarW'(mean) * VarW'(mean);
    return VarW'(sq >> LogB) - msq;
  endfunction

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [KW-1:0]         k_q, k_d;
  logic [ChIdxW-1:0]     ch_q, ch_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [VarW:0]         rem_q, rem_d;
  logic [GainW-1:0]      quo_q, quo_d;
  logic                  sof_q, sof_d, eof_q, eof_d;
  logic [VarW-1:0]       noise_q, noise_d;
  logic                  bypass_q, bypass_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DataW-1:0]      data_out_q, data_out_d;
  logic                  out_start_q, out_start_d;
  logic                  frame_done_q, frame_done_d;
  logic [31:0]           count_q, count_d;
  logic [SumW-1:0]       sum_q [NUM_CHANNELS];
  logic [SumW-1:0]       sum_d [NUM_CHANNELS];
  logic [SqW-1:0]        sq_q [NUM_CHANNELS];
  logic [SqW-1:0]        sq_d [NUM_CHANNELS];
  logic [CH_WIDTH-1:0]   mean_q [NUM_CHANNELS];
  logic [CH_WIDTH-1:0]   mean_d [NUM_CHANNELS];
  logic [VarW-1:0]       var_q [NUM_CHANNELS];
  logic [VarW-1:0]       var_d [NUM_CHANNELS];
  logic [GainW-1:0]      g_q [NUM_CHANNELS];
  logic [GainW-1:0]      g_d [NUM_CHANNELS];
  logic [DataW-1:0]      buf_q [BLOCK_SAMPLES];
  logic                  buf_we;
  logic [IdxW-1:0]       buf_wa;

  logic                  accept, fire;
  logic [VarW-1:0]       div_var, div_num;
  logic                  div_skip, div_bit;
  logic [VarW:0]         div_trial, div_diff;
  logic [DataW-1:0]      emit_px, emit_y;

  assign accept = data_valid && in_ready_q;
  assign fire   = out_valid_q && out_ready;

  // Restoring divider: the first step compares the unshifted numerator so that g=1.0
  // (noise=0) still fits in GAIN_FRAC+1 quotient bits.
  assign div_var   = var_q[ch_q];
  assign div_skip  = (div_var == '0) || (div_var <= noise_q);
  assign div_num   = div_var - noise_q;
  assign div_trial = (cnt_q == '0) ? {1'b0, div_num} : (rem_q << 1);
  assign div_bit   = (div_trial >= {1'b0, div_var});
  assign div_diff  = div_bit ? (div_trial - {1'b0, div_var}) : div_trial;

  always_comb begin
    emit_px = buf_q[k_q[IdxW-1:0]];
    emit_y  = emit_px;
    if (!bypass_q) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        emit_y[c*CH_WIDTH +: CH_WIDTH] = filter_px(emit_px[c*CH_WIDTH +: CH_WIDTH],
                                                   mean_q[c], g_q[c]);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    k_d          = k_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    sof_d        = sof_q;
    eof_d        = eof_q;
    noise_d      = noise_q;
    bypass_d     = bypass_q;
    out_valid_d  = out_valid_q;
    data_out_d   = data_out_q;
    out_start_d  = out_start_q;
    frame_done_d = 1'b0;
    count_d      = count_q;
    buf_we       = 1'b0;
    buf_wa       = idx_q;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      sum_d[c]  = sum_q[c];
      sq_d[c]   = sq_q[c];
      mean_d[c] = mean_q[c];
      var_d[c]  = var_q[c];
      g_d[c]    = g_q[c];
    end

    unique case (state_q)
      StIdle, StLoad: begin
        if (accept && start_data) begin
          // A new block start always restarts at pixel 0, discarding any partial block.
          buf_we  = 1'b1;
          buf_wa  = '0;
          idx_d   = IdxW'(1);
          sof_d   = start_of_frame;
          eof_d   = end_of_frame;
          state_d = StLoad;
          for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            sum_d[c] = SumW'(data_in[c*CH_WIDTH +: CH_WIDTH]);
            sq_d[c]  = SqW'(VarW'(data_in[c*CH_WIDTH +: CH_WIDTH]) *
                            VarW'(data_in[c*CH_WIDTH +: CH_WIDTH]));
          end
        end else if (accept && (state_q == StLoad)) begin
          buf_we = 1'b1;
          idx_d  = idx_q + IdxW'(1);
          for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            sum_d[c] = sum_q[c] + SumW'(data_in[c*CH_WIDTH +: CH_WIDTH]);
            sq_d[c]  = sq_q[c] + SqW'(VarW'(data_in[c*CH_WIDTH +: CH_WIDTH]) *
                                      VarW'(data_in[c*CH_WIDTH +: CH_WIDTH]));
          end
          if (idx_q == IdxW'(BLOCK_SAMPLES - 1)) begin
            state_d  = StStats;
            noise_d  = noise_variance;
            bypass_d = bypass;
            if (sof_q) count_d = '0;
          end
        end
      end
      StStats: begin
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
          mean_d[c] = CH_WIDTH'(sum_q[c] >> LogB);
          var_d[c]  = calc_var(sq_q[c], CH_WIDTH'(sum_q[c] >> LogB));
        end
        ch_d    = '0;
        cnt_d   = '0;
        quo_d   = '0;
        k_d     = '0;
        state_d = bypass_q ? StEmit : StDivide;
      end
      StDivide: begin
        rem_d = div_diff;
        quo_d = (quo_q << 1) | GainW'(div_bit);
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(GAIN_FRAC)) begin
          g_d[ch_q] = div_skip ? '0 : ((quo_q << 1) | GainW'(div_bit));
          cnt_d     = '0;
          quo_d     = '0;
          ch_d      = ch_q + ChIdxW'(1);
          if (ch_q == ChIdxW'(NUM_CHANNELS - 1)) state_d = StEmit;
        end
      end
      StEmit: begin
        if (fire) count_d = count_q + 32'd1;
        if (k_q == KW'(BLOCK_SAMPLES)) begin
          if (fire) begin
            out_valid_d  = 1'b0;
            out_start_d  = 1'b0;
            frame_done_d = eof_q;
            state_d      = StIdle;
          end
        end else if (!out_valid_q || out_ready) begin
          data_out_d  = emit_y;
          out_valid_d = 1'b1;
          out_start_d = (k_q == '0);
          k_d         = k_q + KW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StIdle) || (state_d == StLoad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      k_q          <= '0;
      ch_q         <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      noise_q      <= '0;
      bypass_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      out_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      count_q      <= '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        sum_q[c]  <= '0;
        sq_q[c]   <= '0;
        mean_q[c] <= '0;
        var_q[c]  <= '0;
        g_q[c]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      k_q          <= k_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      noise_q      <= noise_d;
      bypass_q     <= bypass_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      out_start_q  <= out_start_d;
      frame_done_q <= frame_done_d;
      count_q      <= count_d;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        sum_q[c]  <= sum_d[c];
        sq_q[c]   <= sq_d[c];
        mean_q[c] <= mean_d[c];
        var_q[c]  <= var_d[c];
        g_q[c]    <= g_d[c];
      end
    end
  end

  // Pixel storage needs no reset: every block overwrites it from pixel 0 before use.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_wa] <= data_in;
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign data_out        = data_out_q;
  assign out_start_block = out_start_q;
  assign frame_done      = frame_done_q;
  assign data_count      = count_q;

endmodule

// File: tb/tb_wiener_n_channel_block.sv
// Directed bench for wiener_n_channel_block with hand-computed pixel values and latencies.
module tb_wiener_n_channel_block;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_of_frame = 1'b0, end_of_frame = 1'b0, start_data = 1'b0;
  logic        data_valid = 1'b0, in_ready;
  logic [23:0] data_in = '0;
  logic [15:0] noise_variance = '0;
  logic        bypass = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [23:0] data_out;
  logic        out_start_block, frame_done;
  logic [31:0] data_count;

  wiener_n_channel_block #(
    .NUM_CHANNELS (3),
    .CH_WIDTH     (8),
    .BLOCK_SAMPLES(8),
    .GAIN_FRAC    (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_of_frame (start_of_frame),
    .end_of_frame   (end_of_frame),
    .start_data     (start_data),
    .data_valid     (data_valid),
    .in_ready       (in_ready),
    .data_in        (data_in),
    .noise_variance (noise_variance),
    .bypass         (bypass),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_out       (data_out),
    .out_start_block(out_start_block),
    .frame_done     (frame_done),
    .data_count     (data_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] blk [8];
  logic [23:0] got [8];
  logic [23:0] expv [8];
  int          lat;
  bit          stall_bad, ir_bad, start_bad, col_timeout;
  logic        fd_after;
  int          fd_cnt = 0;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic send_block(input int n, input bit sof, input bit eof);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in = blk[i]; start_data = (i == 0); start_of_frame = sof; end_of_frame = eof;
      data_valid = 1'b1;
      for (int w = 0; w < 200 && !in_ready; w++) @(negedge clk);
      @(posedge clk);
    end
  endtask

  task automatic wait_first();
    @(negedge clk);
    data_valid = 1'b0; start_data = 1'b0; start_of_frame = 1'b0; end_of_frame = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic collect(input bit toggle);
    int j = 0;
    int n = 0;
    bit ph = 1'b1;
    bit stalled = 1'b0;
    logic [23:0] held = '0;
    stall_bad = 0; ir_bad = 0; start_bad = 0; col_timeout = 0;
    for (int i = 0; i < 8; i++) got[i] = 'x;
    while (j < 8 && n < 500) begin
      out_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (in_ready !== 1'b0) ir_bad = 1;
      if (stalled && out_valid && data_out !== held) stall_bad = 1;
      if (out_valid) begin
        if (out_ready) begin
          got[j] = data_out;
          if (out_start_block !== (j == 0)) start_bad = 1;
          j++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = data_out;
        end
      end
      @(posedge clk); @(negedge clk); n++;
    end
    if (j < 8) col_timeout = 1;
    fd_after = frame_done;
    out_ready = 1'b1;
  endtask

  function automatic logic [23:0] gain_px(input int i);
    return {8'd0, (i % 2 == 0) ? 8'd10 : 8'd20, (i < 4) ? 8'd0 : 8'd16};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (data_out !== 24'd0) begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
    checks++; if (out_start_block !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_flags got sb=%b fd=%b want 0 0", out_start_block, frame_done);
    end
    checks++; if (data_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", data_count); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_constant();
    noise_variance = 16'd5;
    for (int i = 0; i < 8; i++) blk[i] = 24'h646464;
    send_block(8, 1, 1);
    wait_first();
    checks++; if (lat !== 29) begin errors++; $display("FAIL const_latency got %0d want 29", lat); end
    collect(0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== 24'h646464) begin errors++; $display("FAIL const_px%0d got %h want 646464", i, got[i]); end
    end
    checks++; if (start_bad || col_timeout) begin errors++; $display("FAIL const_start_block got bad=%0b timeout=%0b want 0 0", start_bad, col_timeout); end
    checks++; if (data_count !== 32'd8) begin errors++; $display("FAIL const_count got %0d want 8", data_count); end
    checks++; if (fd_after !== 1'b1) begin errors++; $display("FAIL const_frame_done got %b want 1", fd_after); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL const_in_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_gain();
    int noises [3] = '{16, 64, 0};
    for (int s = 0; s < 3; s++) begin
      noise_variance = 16'(noises[s]);
      for (int i = 0; i < 8; i++) begin
        blk[i] = gain_px(i);
        // ch0: mean 8 var 64; ch1: mean 15 var 25; ch2: constant 0
        case (s)
          0:       expv[i] = {8'd0, (i % 2 == 0) ? 8'd13 : 8'd16, (i < 4) ? 8'd2 : 8'd14};
          1:       expv[i] = {8'd0, 8'd15, 8'd8};
          default: expv[i] = gain_px(i);
        endcase
      end
      send_block(8, 0, 0);
      wait_first();
      checks++; if (lat !== 29) begin errors++; $display("FAIL gain%0d_latency got %0d want 29", s, lat); end
      collect(0);
      for (int i = 0; i < 8; i++) begin
        checks++; if (got[i] !== expv[i]) begin errors++; $display("FAIL gain%0d_px%0d got %h want %h", s, i, got[i], expv[i]); end
      end
      checks++; if (fd_after !== 1'b0) begin errors++; $display("FAIL gain%0d_frame_done got %b want 0", s, fd_after); end
    end
    checks++; if (data_count !== 32'd32) begin errors++; $display("FAIL gain_count got %0d want 32", data_count); end
  endtask

  task automatic test_bypass();
    bypass = 1'b1;
    noise_variance = 16'd16;
    for (int i = 0; i < 8; i++) blk[i] = 24'($urandom);
    send_block(8, 0, 0);
    wait_first();
    checks++; if (lat !== 2) begin errors++; $display("FAIL bypass_latency got %0d want 2", lat); end
    collect(0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== blk[i]) begin errors++; $display("FAIL bypass_px%0d got %h want %h", i, got[i], blk[i]); end
    end
    bypass = 1'b0;
  endtask

  task automatic test_stall();
    noise_variance = 16'd16;
    for (int i = 0; i < 8; i++) begin
      blk[i]  = gain_px(i);
      expv[i] = {8'd0, (i % 2 == 0) ? 8'd13 : 8'd16, (i < 4) ? 8'd2 : 8'd14};
    end
    send_block(8, 0, 0);
    wait_first();
    collect(1);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== expv[i]) begin errors++; $display("FAIL stall_px%0d got %h want %h", i, got[i], expv[i]); end
    end
    checks++; if (stall_bad) begin errors++; $display("FAIL stall_hold got unstable=1 want 0"); end
    checks++; if (ir_bad) begin errors++; $display("FAIL stall_in_ready got high_in_emit=1 want 0"); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_restart_frame();
    int base = fd_cnt;
    noise_variance = 16'd5;
    for (int i = 0; i < 8; i++) blk[i] = 24'hFAFAFA;
    send_block(3, 1, 0);
    for (int b = 0; b < 8; b++) begin
      int bad = 0;
      logic [7:0] v = 8'(10 * b + 5);
      for (int i = 0; i < 8; i++) blk[i] = {v, v, v};
      send_block(8, b == 0, b == 7);
      wait_first();
      collect(0);
      for (int i = 0; i < 8; i++) if (got[i] !== {v, v, v}) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL frame_blk%0d got %0d bad px (px0=%h) want %h", b, bad, got[0], {v, v, v}); end
    end
    @(negedge clk);
    checks++; if (data_count !== 32'd64) begin errors++; $display("FAIL frame_count got %0d want 64", data_count); end
    checks++; if (fd_cnt - base != 1) begin errors++; $display("FAIL frame_done_pulses got %0d want 1", fd_cnt - base); end
  endtask

  task automatic test_reset_mid();
    noise_variance = 16'd16;
    for (int i = 0; i < 8; i++) begin
      blk[i]  = gain_px(i);
      expv[i] = {8'd0, (i % 2 == 0) ? 8'd13 : 8'd16, (i < 4) ? 8'd2 : 8'd14};
    end
    send_block(8, 0, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_divide_handshake got ov=%b ir=%b want 0 0", out_valid, in_ready);
    end
    checks++; if (data_count !== 32'd0) begin errors++; $display("FAIL rst_divide_count got %0d want 0", data_count); end
    @(negedge clk); rst = 1'b0;
    send_block(8, 0, 0);
    wait_first();
    checks++; if (lat !== 29) begin errors++; $display("FAIL rst_recover_latency got %0d want 29", lat); end
    @(posedge clk); @(negedge clk);
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || data_out !== 24'd0 || out_start_block !== 1'b0) begin
      errors++; $display("FAIL rst_emit_outputs got ov=%b do=%h sb=%b want 0 0 0", out_valid, data_out, out_start_block);
    end
    @(negedge clk); rst = 1'b0;
    send_block(8, 0, 0);
    wait_first();
    collect(0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== expv[i]) begin errors++; $display("FAIL rst_recover_px%0d got %h want %h", i, got[i], expv[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_gain();
    test_bypass();
    test_stall();
    test_restart_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
